// File: rtl/positron_layer_serializer.sv
// Purpose : collects one window of NB_POSITRONS parallel posits from a layer of
//           positron engines and replays them as one serial posit stream with
//           sow/eow framing and an rts/rtr handshake.
// Latency : a capture at edge N presents word 0 with rts_o=1 in cycle N+1.
//           After that the block sends one word per cycle while rtr_i=1.
// Backpressure: rtr_i=0 holds posit_o, sow_o, eow_o and the read index.
//           rtr_o depends only on bank state and never on rts_i.
// Optional: define LAYER_SER_DOUBLE_BUF_EN to use two ping-pong banks, so that
//           window W+1 can be captured while window W is still being emitted.
//           In the default build there is one bank, and rtr_o stays low for the
//           whole emission.
// Ports   : clk/rst (sync, active-high); rts_i/eow_i/posit_i/rtr_o form the
//           upstream layer interface; rts_o/sow_o/eow_o/posit_o/rtr_i form the
//           serial stream; desync_o is a sticky lockstep-error flag.
module positron_layer_serializer #(
  parameter int POSIT_WIDTH  = 4,
  parameter int NB_POSITRONS = 16
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NB_POSITRONS-1:0]              rts_i,
  input  logic [NB_POSITRONS-1:0]              eow_i,
  input  logic [NB_POSITRONS*POSIT_WIDTH-1:0]  posit_i,
  output logic                                 rtr_o,
  input  logic                                 rtr_i,
  output logic                                 rts_o,
  output logic                                 sow_o,
  output logic                                 eow_o,
  output logic [POSIT_WIDTH-1:0]               posit_o,
  output logic                                 desync_o
);

  localparam int IDX_W = (NB_POSITRONS > 1) ? $clog2(NB_POSITRONS) : 1;
  localparam int BUS_W = NB_POSITRONS * POSIT_WIDTH;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRONS - 1);

  // Bank pointers advance by XOR with this bit. With a single bank they never
  // move, so bank 1 stays empty and "the other bank" is never full.
`ifdef LAYER_SER_DOUBLE_BUF_EN
  localparam logic SEL_STEP = 1'b1;
`else
  localparam logic SEL_STEP = 1'b0;
`endif

  typedef enum logic {EMPTY, EMIT} state_e;

  state_e             state_q, state_d;
  logic [BUS_W-1:0]   bank_q [2];
  logic [1:0]         full_q, full_d;
  logic               fill_sel_q, fill_sel_d;
  logic               emit_sel_q, emit_sel_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               desync_q, desync_d;

  logic [NB_POSITRONS-1:0] arrived;
  logic all_arrived, any_arrived, capture, xfer, last_xfer, other_full;

  assign arrived     = rts_i & eow_i;
  assign all_arrived = &arrived;
  assign any_arrived = |arrived;
  assign capture     = rtr_o & all_arrived;
  assign xfer        = rts_o & rtr_i;
  assign last_xfer   = xfer && (idx_q == LAST_IDX);
  assign other_full  = full_q[~emit_sel_q];

  assign rtr_o    = ~full_q[fill_sel_q];
  assign rts_o    = (state_q == EMIT);
  assign sow_o    = rts_o && (idx_q == '0);
  assign eow_o    = rts_o && (idx_q == LAST_IDX);
  assign posit_o  = rts_o ? bank_q[emit_sel_q][int'(idx_q)*POSIT_WIDTH +: POSIT_WIDTH]
                          : '0;
  assign desync_o = desync_q;

  always_comb begin
    state_d    = state_q;
    full_d     = full_q;
    fill_sel_d = fill_sel_q;
    emit_sel_d = emit_sel_q;
    idx_d      = idx_q;
    // A partial arrival means the engines have drifted apart. The flag is
    // sticky, and the block keeps waiting for a complete vector.
    desync_d   = desync_q | (any_arrived & ~all_arrived);

    if (capture) begin
      full_d[fill_sel_q] = 1'b1;
      fill_sel_d         = fill_sel_q ^ SEL_STEP;
    end

    if (xfer) begin
      idx_d = last_xfer ? '0 : idx_q + 1'b1;
    end

    // The emitting bank is freed on its last word. A capture in the same
    // cycle always goes to the other bank, so these two cases never collide.
    if (last_xfer) begin
      full_d[emit_sel_q] = 1'b0;
      emit_sel_d         = emit_sel_q ^ SEL_STEP;
    end

    unique case (state_q)
      EMPTY: if (capture) state_d = EMIT;
      EMIT:  if (last_xfer) state_d = (other_full | capture) ? EMIT : EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= EMPTY;
      full_q     <= '0;
      fill_sel_q <= 1'b0;
      emit_sel_q <= 1'b0;
      idx_q      <= '0;
      desync_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      full_q     <= full_d;
      fill_sel_q <= fill_sel_d;
      emit_sel_q <= emit_sel_d;
      idx_q      <= idx_d;
      desync_q   <= desync_d;
    end
  end

  // Bank contents need no reset because posit_o is gated by rts_o.
  always_ff @(posedge clk) begin
    if (capture) bank_q[fill_sel_q] <= posit_i;
  end

endmodule

// File: tb/tb_positron_layer_serializer.sv
module tb_positron_layer_serializer;

`ifdef LAYER_SER_DOUBLE_BUF_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        rtr_i;

  // Four-positron instance
  logic [3:0]  rts_i, eow_i;
  logic [15:0] posit_i;
  logic        rtr_o, rts_o, sow_o, eow_o, desync_o;
  logic [3:0]  posit_o;

  // Single-positron instance
  logic [0:0]  rts1_i, eow1_i;
  logic [3:0]  posit1_i;
  logic        rtr1_o, rts1_o, sow1_o, eow1_o, desync1_o;
  logic [3:0]  posit1_o;

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRONS(4)) u4 (
    .clk(clk), .rst(rst), .rts_i(rts_i), .eow_i(eow_i), .posit_i(posit_i),
    .rtr_o(rtr_o), .rtr_i(rtr_i), .rts_o(rts_o), .sow_o(sow_o), .eow_o(eow_o),
    .posit_o(posit_o), .desync_o(desync_o)
  );

  positron_layer_serializer #(.POSIT_WIDTH(4), .NB_POSITRONS(1)) u1 (
    .clk(clk), .rst(rst), .rts_i(rts1_i), .eow_i(eow1_i), .posit_i(posit1_i),
    .rtr_o(rtr1_o), .rtr_i(rtr_i), .rts_o(rts1_o), .sow_o(sow1_o), .eow_o(eow1_o),
    .posit_o(posit1_o), .desync_o(desync1_o)
  );

  int total = 0;
  int bad   = 0;

  logic [3:0] exp_a [4] = '{4'h7, 4'h0, 4'h3, 4'hD};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [15:0] w);
    posit_i = w;
    rts_i   = 4'hF;
    eow_i   = 4'hF;
  endtask

  task automatic idle_in();
    rts_i = 4'h0;
    eow_i = 4'h0;
  endtask

  task automatic chk_word(input string tag, input logic [3:0] w, input logic s, input logic e);
    chk({tag, "_rts"},   rts_o,   1);
    chk({tag, "_posit"}, posit_o, w);
    chk({tag, "_sow"},   sow_o,   s);
    chk({tag, "_eow"},   eow_o,   e);
  endtask

  initial begin
    rst = 1'b1; rtr_i = 1'b1;
    rts_i = '0; eow_i = '0; posit_i = '0;
    rts1_i = '0; eow1_i = '0; posit1_i = '0;
    step(); step();
    rst = 1'b0;

    // Reset state
    chk("rst_rts", rts_o, 0);
    chk("rst_sow", sow_o, 0);
    chk("rst_eow", eow_o, 0);
    chk("rst_posit", posit_o, 0);
    chk("rst_desync", desync_o, 0);
    chk("rst_rtr", rtr_o, 1);
    chk("rst1_rtr", rtr1_o, 1);
    chk("rst1_rts", rts1_o, 0);

    // Single window, no backpressure
    present(16'hD307);
    step();
    idle_in();
    chk("w1_rtr_emit", rtr_o, DB);
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("w1_%0d", i), exp_a[i], i == 0, i == 3);
      step();
    end
    chk("w1_done_rts", rts_o, 0);
    chk("w1_done_rtr", rtr_o, 1);

    // Backpressure: word 0 is held for three cycles
    present(16'hD307);
    step();
    idle_in();
    rtr_i = 1'b0;
    chk_word("bp_hold0", 4'h7, 1, 0);
    step();
    chk_word("bp_hold1", 4'h7, 1, 0);
    step();
    rtr_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("bp_%0d", i), exp_a[i], i == 0, i == 3);
      step();
    end
    chk("bp_done_rts", rts_o, 0);

    // Back-to-back windows
    present(16'hD307);
    step();
    idle_in();
    if (DB) begin
      for (int i = 0; i < 8; i++) begin
        chk_word($sformatf("b2b_%0d", i), (i < 4) ? exp_a[i] : 4'h8, (i % 4) == 0, (i % 4) == 3);
        if (i == 0) present(16'h8888);
        if (i == 1) begin
          idle_in();
          chk("b2b_rtr_both_full", rtr_o, 0);
        end
        step();
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        chk_word($sformatf("b2b_%0d", i), exp_a[i], i == 0, i == 3);
        chk($sformatf("b2b_rtr_%0d", i), rtr_o, 0);
        if (i == 1) present(16'h8888);
        step();
      end
      chk("b2b_gap_rts", rts_o, 0);
      chk("b2b_gap_rtr", rtr_o, 1);
      step();
      idle_in();
      for (int i = 0; i < 4; i++) begin
        chk_word($sformatf("b2b_second_%0d", i), 4'h8, i == 0, i == 3);
        step();
      end
    end
    chk("b2b_done_rts", rts_o, 0);
    chk("b2b_desync", desync_o, 0);

    // Reset in the middle of a window
    present(16'hD307);
    step();
    idle_in();
    chk_word("rm_0", 4'h7, 1, 0);
    step();
    chk_word("rm_1", 4'h0, 0, 0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rm_rts", rts_o, 0);
    chk("rm_rtr", rtr_o, 1);
    chk("rm_posit", posit_o, 0);
    chk("rm_sow", sow_o, 0);
    step();
    chk("rm_rts_idle", rts_o, 0);
    present(16'h4321);
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("rm_next_%0d", i), 4'(i + 1), i == 0, i == 3);
      step();
    end
    chk("rm_done_rts", rts_o, 0);

    // Single-positron layer
    posit1_i = 4'h9; rts1_i = 1'b1; eow1_i = 1'b1;
    step();
    rts1_i = 1'b0; eow1_i = 1'b0;
    chk("nb1_rts", rts1_o, 1);
    chk("nb1_posit", posit1_o, 4'h9);
    chk("nb1_sow", sow1_o, 1);
    chk("nb1_eow", eow1_o, 1);
    step();
    chk("nb1_done_rts", rts1_o, 0);
    chk("nb1_done_rtr", rtr1_o, 1);

    // Desync: a partial vector sets the sticky flag, and capture waits for all four
    chk("ds_pre", desync_o, 0);
    posit_i = 16'hD307; rts_i = 4'b0111; eow_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("ds_flag_%0d", i), desync_o, 1);
      chk($sformatf("ds_nocap_%0d", i), rts_o, 0);
    end
    rts_i = 4'hF;
    step();
    idle_in();
    for (int i = 0; i < 4; i++) begin
      chk_word($sformatf("ds_%0d", i), exp_a[i], i == 0, i == 3);
      chk($sformatf("ds_sticky_%0d", i), desync_o, 1);
      step();
    end
    chk("ds_done_rts", rts_o, 0);
    chk("ds_end", desync_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
